// File: rtl/dog_extrema_detector.sv
// Scale-space extremum detector over three raster-ordered DoG streams.
// It flags middle-scale pixels that are strict 3x3x3 maxima or minima and pass a contrast test.
module dog_extrema_detector #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int CONTRAST_TH = 3
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     ivalid,
    input  logic                     isof,
    input  logic signed [8:0]        DOGImageData1,
    input  logic signed [8:0]        DOGImageData2,
    input  logic signed [8:0]        DOGImageData3,
    output logic                     okp_valid,
    output logic                     okp_max,
    output logic [$clog2(IMG_W)-1:0] okp_x,
    output logic [$clog2(IMG_H)-1:0] okp_y,
    output logic signed [8:0]        okp_value,
    output logic                     oframe_done
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    // Handshake: ivalid alone qualifies a pixel; there is no backpressure, so every
    // asserted cycle is an accept. okp_valid and oframe_done are single-cycle pulses.

    logic [XW-1:0] x_q, x_d, cur_x;
    logic [YW-1:0] y_q, y_d, cur_y;
    logic          last_pix;

    always_comb begin
        cur_x = isof ? '0 : x_q;
        cur_y = isof ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (ivalid) begin
            if (cur_x == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
            end else begin
                x_d = cur_x + XW'(1);
                y_d = cur_y;
            end
        end
    end

    assign last_pix = (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));

    logic signed [8:0] din [3];

    always_comb begin
        din[0] = DOGImageData1;
        din[1] = DOGImageData2;
        din[2] = DOGImageData3;
    end

    // Line buffers hold rows y-1 (mid) and y-2 (top); contents are only trusted once masked by y >= 2.
    logic signed [8:0] lb_mid_q [3][IMG_W];
    logic signed [8:0] lb_top_q [3][IMG_W];
    logic signed [8:0] win_q    [3][3][3];

    always_ff @(posedge iclk) begin
        if (ivalid) begin
            for (int s = 0; s < 3; s++) begin
                lb_mid_q[s][cur_x] <= din[s];
                lb_top_q[s][cur_x] <= lb_mid_q[s][cur_x];
                for (int r = 0; r < 3; r++) begin
                    win_q[s][r][0] <= win_q[s][r][1];
                    win_q[s][r][1] <= win_q[s][r][2];
                end
                win_q[s][0][2] <= lb_top_q[s][cur_x];
                win_q[s][1][2] <= lb_mid_q[s][cur_x];
                win_q[s][2][2] <= din[s];
            end
        end
    end

    logic              win_eval_q;
    logic [XW-1:0]     cx_q;
    logic [YW-1:0]     cy_q;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            win_eval_q  <= 1'b0;
            cx_q        <= '0;
            cy_q        <= '0;
            oframe_done <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            win_eval_q  <= ivalid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
            oframe_done <= ivalid && last_pix;
            if (ivalid) begin
                cx_q <= cur_x - XW'(1);
                cy_q <= cur_y - YW'(1);
            end
        end
    end

    // Bit 13 is the centre compared with itself; it is forced true so the full AND reduces the 26 neighbours.
    logic signed [8:0] center;
    logic signed [9:0] cext;
    logic [26:0]       gt_d, lt_d;
    logic [9:0]        abs_d;

    always_comb begin
        center = win_q[1][1][1];
        gt_d   = '0;
        lt_d   = '0;
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    gt_d[s*9 + r*3 + c] = center > win_q[s][r][c];
                    lt_d[s*9 + r*3 + c] = center < win_q[s][r][c];
                end
            end
        end
        gt_d[13] = 1'b1;
        lt_d[13] = 1'b1;
        cext     = {center[8], center};
        abs_d    = cext[9] ? -cext : cext;
    end

    logic              s1_valid_q;
    logic [26:0]       gt_q, lt_q;
    logic [9:0]        abs_q;
    logic [XW-1:0]     s1_x_q;
    logic [YW-1:0]     s1_y_q;
    logic signed [8:0] s1_val_q;
    logic              is_max, kp_hit;

    assign is_max = &gt_q;
    assign kp_hit = s1_valid_q && (is_max || (&lt_q)) && (abs_q > 10'(CONTRAST_TH));

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s1_valid_q <= 1'b0;
            gt_q       <= '0;
            lt_q       <= '0;
            abs_q      <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_val_q   <= '0;
            okp_valid  <= 1'b0;
            okp_max    <= 1'b0;
            okp_x      <= '0;
            okp_y      <= '0;
            okp_value  <= '0;
        end else begin
            s1_valid_q <= win_eval_q;
            gt_q       <= gt_d;
            lt_q       <= lt_d;
            abs_q      <= abs_d;
            s1_x_q     <= cx_q;
            s1_y_q     <= cy_q;
            s1_val_q   <= center;
            okp_valid  <= kp_hit;
            if (kp_hit) begin
                okp_max   <= is_max;
                okp_x     <= s1_x_q;
                okp_y     <= s1_y_q;
                okp_value <= s1_val_q;
            end
        end
    end

endmodule

// File: tb/tb_dog_extrema_detector.sv
// Scoreboard bench for dog_extrema_detector on an 8x8 frame with directed spike patterns.
module tb_dog_extrema_detector;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int TH = 3;
  localparam int EW = 23;  // {max, x[2:0], y[2:0], value[8:0], trigger pixel index[6:0]}

  logic              iclk = 1'b0;
  logic              irst_n;
  logic              ivalid;
  logic              isof;
  logic signed [8:0] d1, d2, d3;
  logic              okp_valid, okp_max, oframe_done;
  logic [2:0]        okp_x, okp_y;
  logic signed [8:0] okp_value;

  dog_extrema_detector #(.IMG_W(W), .IMG_H(H), .CONTRAST_TH(TH)) dut (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .isof(isof),
    .DOGImageData1(d1), .DOGImageData2(d2), .DOGImageData3(d3),
    .okp_valid(okp_valid), .okp_max(okp_max), .okp_x(okp_x), .okp_y(okp_y),
    .okp_value(okp_value), .oframe_done(oframe_done)
  );

  // clock / reset
  always #5 iclk = ~iclk;

  logic signed [8:0] f1 [64];
  logic signed [8:0] f2 [64];
  logic signed [8:0] f3 [64];
  logic [EW-1:0]     exp_q [$];
  int                tb_idx;
  int                idx_d1, idx_d2, idx_d3;
  logic              fd_exp;
  int                n_checks = 0;
  int                n_fail = 0;
  int                fd_count = 0;

  // history of accepted pixel indices, used to check keypoint latency
  always @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      idx_d1 <= -1;
      idx_d2 <= -1;
      idx_d3 <= -1;
      fd_exp <= 1'b0;
    end else begin
      idx_d1 <= ivalid ? tb_idx : -1;
      idx_d2 <= idx_d1;
      idx_d3 <= idx_d2;
      fd_exp <= ivalid && (tb_idx == W*H-1);
    end
  end

  // driver tasks
  task automatic clear_frame();
    for (int i = 0; i < 64; i++) begin
      f1[i] = '0;
      f2[i] = '0;
      f3[i] = '0;
    end
  endtask

  task automatic push_kp(input logic mx, input int x, input int y, input logic signed [8:0] v);
    logic [6:0] trig;
    trig = 7'((y + 1) * W + x + 1);
    exp_q.push_back({mx, 3'(x), 3'(y), v, trig});
  endtask

  task automatic drive(input int gap_max, input int last_idx);
    int g;
    for (int i = 0; i <= last_idx; i++) begin
      g = $urandom_range(gap_max, 0);
      repeat (g) begin
        @(negedge iclk);
        ivalid = 1'b0;
        isof   = 1'b0;
      end
      @(negedge iclk);
      ivalid = 1'b1;
      isof   = (i == 0);
      d1     = f1[i];
      d2     = f2[i];
      d3     = f3[i];
      tb_idx = i;
    end
    @(negedge iclk);
    ivalid = 1'b0;
    isof   = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge iclk) begin
    logic [EW-1:0] e;
    if (irst_n) begin
      if (okp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_kp: got max=%0b x=%0d y=%0d value=%0d, required no keypoint",
                   okp_max, okp_x, okp_y, okp_value);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if ({okp_max, okp_x, okp_y, okp_value} !== e[22:7]) begin
            n_fail++;
            $display("FAIL kp_fields: got max=%0b x=%0d y=%0d value=%0d, required max=%0b x=%0d y=%0d value=%0d",
                     okp_max, okp_x, okp_y, okp_value, e[22], e[21:19], e[18:16], $signed(e[15:7]));
          end
          n_checks++;
          if (idx_d3 != int'(e[6:0])) begin
            n_fail++;
            $display("FAIL kp_latency: got pixel index %0d three edges back, required %0d",
                     idx_d3, int'(e[6:0]));
          end
        end
      end
      if (oframe_done || fd_exp) begin
        n_checks++;
        if (oframe_done !== fd_exp) begin
          n_fail++;
          $display("FAIL frame_done: got %0b, required %0b", oframe_done, fd_exp);
        end
      end
      if (oframe_done) fd_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required the bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    irst_n = 1'b0;
    ivalid = 1'b0;
    isof   = 1'b0;
    d1     = '0;
    d2     = '0;
    d3     = '0;
    tb_idx = 0;
    clear_frame();
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_okp_valid", int'(okp_valid), 0);
    chk("rst_okp_max", int'(okp_max), 0);
    chk("rst_okp_x", int'(okp_x), 0);
    chk("rst_okp_y", int'(okp_y), 0);
    chk("rst_okp_value", int'(okp_value), 0);
    chk("rst_frame_done", int'(oframe_done), 0);
    @(negedge iclk);
    irst_n = 1'b1;

    // all zero frame: no keypoints, one frame_done
    clear_frame();
    drive(0, 63);

    // positive spike -> maximum at (3,4)
    clear_frame();
    f2[4*W+3] = 9'sd50;
    push_kp(1'b1, 3, 4, 9'sd50);
    drive(0, 63);

    // most negative value -> minimum at (5,2)
    clear_frame();
    f2[2*W+5] = 9'h100;
    push_kp(1'b0, 5, 2, 9'h100);
    drive(0, 63);

    // contrast boundary: |3| rejected, |-4| accepted
    clear_frame();
    f2[2*W+5] = 9'sd3;
    f2[5*W+2] = -9'sd4;
    push_kp(1'b0, 2, 5, -9'sd4);
    drive(0, 63);

    // tie with lower scale, and spikes on border columns
    clear_frame();
    f2[4*W+3] = 9'sd50;
    f1[4*W+3] = 9'sd50;
    f2[3*W+0] = 9'sd50;
    f2[6*W+7] = 9'sd50;
    drive(0, 63);

    // spike again with random input bubbles
    clear_frame();
    f2[4*W+3] = 9'sd50;
    push_kp(1'b1, 3, 4, 9'sd50);
    drive(5, 63);

    // reset while the (3,4) keypoint is in flight
    clear_frame();
    f2[4*W+3] = 9'sd50;
    drive(0, 44);
    @(posedge iclk);
    #1 irst_n = 1'b0;
    #1;
    chk("midrst_okp_valid", int'(okp_valid), 0);
    chk("midrst_okp_max", int'(okp_max), 0);
    chk("midrst_okp_x", int'(okp_x), 0);
    chk("midrst_okp_y", int'(okp_y), 0);
    chk("midrst_okp_value", int'(okp_value), 0);
    chk("midrst_frame_done", int'(oframe_done), 0);
    repeat (2) @(negedge iclk);
    irst_n = 1'b1;

    // fresh frame after reset with spike at (2,2)
    clear_frame();
    f2[2*W+2] = 9'sd50;
    push_kp(1'b1, 2, 2, 9'sd50);
    drive(0, 63);

    repeat (10) @(negedge iclk);
    chk("expected_queue_drained", exp_q.size(), 0);
    chk("frame_done_count", fd_count, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
